// File: rtl/jpeg_rld.sv
// JPEG run-length decoder: expands (run, amplitude), ZRL and EOB symbols into 64 zigzag coefficients.
// Optional macro JPEG_RLD_OVERFLOW_CHECK_EN flags and truncates symbols that would run past index 63.
module jpeg_rld #(
  parameter int unsigned COEF_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [3:0]        s_run,
  input  logic [COEF_W-1:0] s_amp,
  input  logic              s_eob,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [COEF_W-1:0] m_coef,
  output logic [5:0]        m_index,
  output logic              m_last,
  output logic              err
);
  localparam int unsigned IDX_W = 6;
  localparam int unsigned RUN_W = 4;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(63);

  typedef enum logic [1:0] {ACCEPT, RUN, AMP, FILL} state_e;

  state_e            state_q, state_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [COEF_W-1:0] amp_q, amp_d;
  logic [IDX_W-1:0]  idx_q;
  logic              live_q;
  logic              adv_c, take_c, emit_c, at_last_c;
  logic [COEF_W-1:0] coef_c;
`ifdef JPEG_RLD_OVERFLOW_CHECK_EN
  logic              err_q, ovf_c;
`endif

  // The output register may be reloaded when empty or drained this cycle.
  assign adv_c     = !m_valid || m_ready;
  assign s_ready   = live_q && (state_q == ACCEPT) && adv_c;
  assign take_c    = s_valid && s_ready;
  assign at_last_c = (idx_q == IDX_LAST);

  // The first coefficient of a symbol is loaded on its acceptance edge, so
  // run_q counts the zeros still owed after the one being emitted.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    amp_d   = amp_q;
    emit_c  = 1'b0;
    coef_c  = '0;
`ifdef JPEG_RLD_OVERFLOW_CHECK_EN
    ovf_c   = 1'b0;
`endif
    if (adv_c) begin
      case (state_q)
        ACCEPT: begin
          if (take_c) begin
            emit_c = 1'b1;
            if (s_eob) begin
              state_d = at_last_c ? ACCEPT : FILL;
            end else if (s_run == RUN_W'(0)) begin
              coef_c = s_amp;
            end else begin
              amp_d   = s_amp;
              run_d   = s_run - RUN_W'(1);
              state_d = (s_run == RUN_W'(1)) ? AMP : RUN;
`ifdef JPEG_RLD_OVERFLOW_CHECK_EN
              if (at_last_c) begin
                state_d = ACCEPT;
                ovf_c   = 1'b1;
              end
`endif
            end
          end
        end
        RUN: begin
          emit_c  = 1'b1;
          run_d   = run_q - RUN_W'(1);
          state_d = (run_q == RUN_W'(1)) ? AMP : RUN;
`ifdef JPEG_RLD_OVERFLOW_CHECK_EN
          if (at_last_c) begin
            state_d = ACCEPT;
            ovf_c   = 1'b1;
          end
`endif
        end
        AMP: begin
          emit_c  = 1'b1;
          coef_c  = amp_q;
          state_d = ACCEPT;
        end
        FILL: begin
          emit_c = 1'b1;
          if (at_last_c) state_d = ACCEPT;
        end
        default: state_d = ACCEPT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCEPT;
      run_q   <= '0;
      amp_q   <= '0;
      idx_q   <= '0;
      live_q  <= 1'b0;
      m_valid <= 1'b0;
      m_coef  <= '0;
      m_index <= '0;
      m_last  <= 1'b0;
`ifdef JPEG_RLD_OVERFLOW_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      live_q  <= 1'b1;
      state_q <= state_d;
      run_q   <= run_d;
      amp_q   <= amp_d;
      if (adv_c) begin
        m_valid <= emit_c;
        if (emit_c) begin
          m_coef  <= coef_c;
          m_index <= idx_q;
          m_last  <= at_last_c;
          idx_q   <= idx_q + IDX_W'(1);
        end
      end
`ifdef JPEG_RLD_OVERFLOW_CHECK_EN
      if (ovf_c) err_q <= 1'b1;
`endif
    end
  end

`ifdef JPEG_RLD_OVERFLOW_CHECK_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
